// File: rtl/spi_master_multi.sv
// SPI master with runtime CPOL/CPHA and bit order, configurable word width and SCLK divider,
// and one-hot active-low slave selects. One word per valid/ready handshake.
module spi_master_multi #(
  parameter int WORD_LENGTH      = 8,
  parameter int CLK_PER_HALF_BIT = 2,
  parameter int NUM_SS           = 4,
  localparam int SSW             = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   tx_valid,
  output logic                   tx_ready,
  input  logic [WORD_LENGTH-1:0] tx_data,
  input  logic [SSW-1:0]         ss_sel,
  input  logic                   cpol,
  input  logic                   cpha,
  input  logic                   lsb_first,
  output logic                   rx_valid,
  output logic [WORD_LENGTH-1:0] rx_data,
  output logic                   sel_err,
  output logic                   busy,
  output logic                   sclk,
  output logic                   mosi,
  input  logic                   miso,
  output logic [NUM_SS-1:0]      ss_n
);

  localparam int W  = WORD_LENGTH;
  localparam int H  = CLK_PER_HALF_BIT;
  localparam int HW = $clog2(H + 1);
  localparam int EW = $clog2(2 * W + 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t         state, state_n;
  logic [HW-1:0]  hcnt;
  logic [EW-1:0]  ecnt;
  logic [W-1:0]   tx_sh, rx_sh;
  logic           cpol_q, cpha_q, lsb_q, sel_bad_q;
  logic           h_end, last_edge, lead, do_smp, do_shf;

  assign h_end     = (hcnt == HW'(H - 1));
  assign last_edge = (ecnt == EW'(2 * W - 1));
  assign lead      = ~ecnt[0];
  // Leading edges are the even-numbered SCLK toggles; CPHA swaps the sample/shift roles.
  assign do_smp    = cpha_q ? ~lead : lead;
  assign do_shf    = cpha_q ? (lead && (ecnt != '0)) : (~lead && !last_edge);

  assign tx_ready = (state == IDLE);
  assign busy     = ~tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:  if (tx_valid)             state_n = SETUP;
      SETUP: if (h_end)                state_n = XFER;
      XFER:  if (h_end && last_edge)   state_n = HOLD;
      HOLD:  if (h_end)                state_n = IDLE;
      default:                         state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              hcnt <= '0;
    else if (state == IDLE)  hcnt <= '0;
    else                     hcnt <= h_end ? '0 : hcnt + HW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ecnt      <= '0;
      tx_sh     <= '0;
      rx_sh     <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      sel_bad_q <= 1'b0;
      sclk      <= 1'b0;
      mosi      <= 1'b0;
      ss_n      <= '1;
      rx_valid  <= 1'b0;
      rx_data   <= '0;
      sel_err   <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      sel_err  <= 1'b0;
      case (state)
        IDLE: if (tx_valid) begin
          tx_sh     <= tx_data;
          rx_sh     <= '0;
          ecnt      <= '0;
          cpol_q    <= cpol;
          cpha_q    <= cpha;
          lsb_q     <= lsb_first;
          sel_bad_q <= (32'(ss_sel) >= 32'(NUM_SS));
          sclk      <= cpol;
          mosi      <= lsb_first ? tx_data[0] : tx_data[W-1];
          // An out-of-range index matches no line, so every select stays high.
          for (int i = 0; i < NUM_SS; i++) ss_n[i] <= (32'(ss_sel) != 32'(i));
        end
        XFER: if (h_end) begin
          sclk <= ~sclk;
          ecnt <= ecnt + EW'(1);
          if (do_smp) begin
            if (lsb_q) rx_sh <= {miso, rx_sh[W-1:1]};
            else       rx_sh <= {rx_sh[W-2:0], miso};
          end
          if (do_shf) begin
            if (lsb_q) begin
              mosi  <= tx_sh[1];
              tx_sh <= tx_sh >> 1;
            end else begin
              mosi  <= tx_sh[W-2];
              tx_sh <= tx_sh << 1;
            end
          end
        end
        HOLD: if (h_end) begin
          ss_n     <= '1;
          sclk     <= cpol_q;
          rx_valid <= 1'b1;
          rx_data  <= rx_sh;
          sel_err  <= sel_bad_q;
        end
        default: ;
      endcase
    end
  end

endmodule
